board_grid_renderer: RTL
========================

Name: board_grid_renderer

Overview:
- Parametrised pixel-colour generator for an NxN tic-tac-toe style board on the 640x480 VGA path.
- Sits between the game FSM and VGA_ctrler. Takes pixel_column/pixel_row and game state; returns 3/3/2 RGB with fixed 2-cycle latency.
- Generalises the fixed 3x3 renderer:
  - grid size and geometry are parameters;
  - board state is latched once per frame (no tearing);
  - blinking win/error indication;
  - cursor highlight.

Parameters:
- GRID_N, 3, cells per row/column (2..8).
- ORIGIN_X, 50, left pixel of board area.
- ORIGIN_Y, 50, top pixel of board area.
- CELL_W, 170, cell width in pixels.
- CELL_H, 120, cell height in pixels.
- LINE_W, 10, grid-line thickness in pixels.
- CURSOR_W, 4, cursor frame thickness inside cell.
- BLINK_FRAMES, 30, frames per blink half-period (>=1).
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- pix_x  in  10  current pixel column from VGA_ctrler.
- pix_y  in  10  current pixel row from VGA_ctrler.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- game_state  in  3  0/1 turn P1/P2, 2/3 win P1/P2, 4 error, 5 draw.
- p1_cells  in  GRID_N*GRID_N  P1 occupancy, bit i = cell i, row-major.
- p2_cells  in  GRID_N*GRID_N  P2 occupancy.
- cursor_idx  in  $clog2(GRID_N*GRID_N)  selected cell.
- cursor_valid  in  1  cursor display enable.
- r  out  3  red.
- g  out  3  green.
- b  out  2  blue.

Behaviour:
- Reset (async, rst_n low):
  - r/g/b = 0.
  - Pipeline registers cleared.
  - Shadow state = 0.
  - Blink counter = 0.
  - blink_on = 1.
- Release is synchronous to clk. Reset mid-frame forces black immediately; normal output resumes 2 cycles after the first valid pixel.
- Geometry:
  - Column c spans [ORIGIN_X + c*(CELL_W+LINE_W), +CELL_W). The following LINE_W pixels are a vertical grid line (except after the last column).
  - Rows are the same with ORIGIN_Y/CELL_H.
  - Board width = GRID_N*CELL_W + (GRID_N-1)*LINE_W; height analogous.
  - Cell index = row*GRID_N + col.
- Stage 1 (cycle t+1): register region class (OFFSCREEN, BORDER, LINE, CELL), cell index, and in-cell x/y offsets.
  - Comparator chain is generated from the parameters; no dividers.
- Stage 2 (cycle t+2): colour mux into r/g/b registers. Pixel at cycle t appears at t+2.
- Colours, first matching rule wins:
  - OFFSCREEN (pix_x>=H_ACTIVE or pix_y>=V_ACTIVE): 0/0/0.
  - BORDER (outside the board rectangle):
    - states 0-3: 7/0/0;
    - state 4: 7/0/0 when blink_on, else 0/0/0;
    - state 5: 7/7/0;
    - states 6/7: treated as 0.
  - LINE: 7/7/3.
  - CELL cursor frame (cursor_valid, cursor_idx < GRID_N*GRID_N, state 0/1, in-cell offset < CURSOR_W from any cell edge): 7/7/0.
  - CELL with both p1 and p2 bits set: 7/0/3 (conflict marker).
  - CELL with p1 set: 0/0/3. CELL with p2 set: 0/7/0.
    - In state 2, P1 cells go black when blink_on = 0.
    - In state 3, P2 cells go black when blink_on = 0.
  - Empty CELL: 0/0/0.
- Snapshot:
  - On the frame_start cycle, p1_cells, p2_cells, game_state, cursor_idx and cursor_valid are copied into shadow registers.
  - Rendering uses shadow values only; they take effect from the next cycle.
- Blink:
  - Counter increments on each frame_start.
  - On reaching BLINK_FRAMES-1 with frame_start, the counter wraps to 0 and blink_on toggles.
  - The counter runs in all states.
- pix_x/pix_y are not required to step by one per clock. Each cycle is classified independently.

Optional Feature:
- Macro BOARD_SNAPSHOT_EN.
- Defined: per-frame shadow latching as above.
- Undefined:
  - shadow registers are removed;
  - live inputs feed stage 1 directly, so changes are visible 2 cycles later;
  - blink counter is unaffected.

Test Plan:
- Reset: rst_n=0 -> rgb 0/0/0 with no clock edge. Release, pix=(10,10), state 0 -> rgb 7/0/0 at t+2.
- p1_cells=9'b000010000, frame_start pulse, pix=(300,240) -> 0/0/3 at t+2. pix=(225,240) (line 220..229) -> 7/7/3.
- Snapshot: change p2_cells to 9'b000010000 without frame_start, pix=(300,240) -> still 0/0/3. After frame_start -> 7/0/3 (conflict).
- Blink: BLINK_FRAMES=2, state 2, p1 cell0, pix=(100,100):
  - frames 0-1 -> 0/0/3;
  - frames 2-3 -> 0/0/0;
  - frames 4-5 -> 0/0/3.
  - Border at (10,10) stays 7/0/0 throughout.
- Cursor: cursor_idx=8, valid, state 1, CURSOR_W=4:
  - pix=(410,310) -> 7/7/0;
  - pix=(414,314) -> 0/0/0;
  - state 2 -> no cursor;
  - cursor_idx=9 -> no cursor.
- Boundaries: pix=(640,100) -> 0/0/0; pix=(579,429) -> cell 8 colour; pix=(580,429) -> 7/0/0; state 5 border -> 7/7/0.

Source files
------------

// File: rtl/board_grid_renderer.sv
// Two-stage pixel colour generator for an NxN board on the 640x480 VGA path.
// Define BOARD_SNAPSHOT_EN to latch board state once per frame; otherwise live inputs are rendered.
module board_grid_renderer #(
  parameter int unsigned GRID_N       = 3,
  parameter int unsigned ORIGIN_X     = 50,
  parameter int unsigned ORIGIN_Y     = 50,
  parameter int unsigned CELL_W       = 170,
  parameter int unsigned CELL_H       = 120,
  parameter int unsigned LINE_W       = 10,
  parameter int unsigned CURSOR_W     = 4,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [9:0]                          pix_x,
  input  logic [9:0]                          pix_y,
  input  logic                                frame_start,
  input  logic [2:0]                          game_state,
  input  logic [GRID_N*GRID_N-1:0]            p1_cells,
  input  logic [GRID_N*GRID_N-1:0]            p2_cells,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]    cursor_idx,
  input  logic                                cursor_valid,
  output logic [2:0]                          r,
  output logic [2:0]                          g,
  output logic [1:0]                          b
);

  localparam int unsigned NC      = GRID_N * GRID_N;
  localparam int unsigned IDXW    = $clog2(NC);
  localparam int unsigned PITCH_X = CELL_W + LINE_W;
  localparam int unsigned PITCH_Y = CELL_H + LINE_W;
  localparam int unsigned BOARD_W = GRID_N * CELL_W + (GRID_N - 1) * LINE_W;
  localparam int unsigned BOARD_H = GRID_N * CELL_H + (GRID_N - 1) * LINE_W;
  localparam int unsigned OFFW    = $clog2(((CELL_W > CELL_H) ? CELL_W : CELL_H) + 1);
  localparam int unsigned CNTW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {OFFSCREEN, BORDER, LINE, CELL} region_t;

  logic [NC-1:0]   srcP1, srcP2;
  logic [2:0]      srcState;
  logic [IDXW-1:0] srcCurIdx;
  logic            srcCurValid;

`ifdef BOARD_SNAPSHOT_EN
  logic [NC-1:0]   shP1, shP2;
  logic [2:0]      shState;
  logic [IDXW-1:0] shCurIdx;
  logic            shCurValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shP1       <= '0;
      shP2       <= '0;
      shState    <= '0;
      shCurIdx   <= '0;
      shCurValid <= 1'b0;
    end else if (frame_start) begin
      shP1       <= p1_cells;
      shP2       <= p2_cells;
      shState    <= game_state;
      shCurIdx   <= cursor_idx;
      shCurValid <= cursor_valid;
    end
  end

  always_comb begin
    srcP1       = shP1;
    srcP2       = shP2;
    srcState    = shState;
    srcCurIdx   = shCurIdx;
    srcCurValid = shCurValid;
  end
`else
  always_comb begin
    srcP1       = p1_cells;
    srcP2       = p2_cells;
    srcState    = game_state;
    srcCurIdx   = cursor_idx;
    srcCurValid = cursor_valid;
  end
`endif

  logic [CNTW-1:0] blinkCnt;
  logic            blinkOn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt <= '0;
      blinkOn  <= 1'b1;
    end else if (frame_start) begin
      if (blinkCnt == CNTW'(BLINK_FRAMES - 1)) begin
        blinkCnt <= '0;
        blinkOn  <= ~blinkOn;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  // Stage 1: per-column/per-row range compares replace division by the cell pitch.
  int unsigned     px, py, colSel, rowSel;
  logic            colHit, rowHit;
  logic [OFFW-1:0] offXn, offYn;
  logic [IDXW-1:0] cellIdxN;
  region_t         regionN;

  always_comb begin
    px     = 32'(pix_x);
    py     = 32'(pix_y);
    colHit = 1'b0;
    rowHit = 1'b0;
    colSel = 0;
    rowSel = 0;
    offXn  = '0;
    offYn  = '0;
    for (int unsigned c = 0; c < GRID_N; c++) begin
      if (px >= ORIGIN_X + c * PITCH_X && px < ORIGIN_X + c * PITCH_X + CELL_W) begin
        colHit = 1'b1;
        colSel = c;
        offXn  = OFFW'(px - (ORIGIN_X + c * PITCH_X));
      end
      if (py >= ORIGIN_Y + c * PITCH_Y && py < ORIGIN_Y + c * PITCH_Y + CELL_H) begin
        rowHit = 1'b1;
        rowSel = c;
        offYn  = OFFW'(py - (ORIGIN_Y + c * PITCH_Y));
      end
    end
    cellIdxN = IDXW'(rowSel * GRID_N + colSel);
    if (px >= H_ACTIVE || py >= V_ACTIVE)
      regionN = OFFSCREEN;
    else if (px < ORIGIN_X || px >= ORIGIN_X + BOARD_W || py < ORIGIN_Y || py >= ORIGIN_Y + BOARD_H)
      regionN = BORDER;
    else if (colHit && rowHit)
      regionN = CELL;
    else
      regionN = LINE;
  end

  region_t         regionQ;
  logic [OFFW-1:0] offXQ, offYQ;
  logic            p1Q, p2Q, curQ, blinkQ;
  logic [2:0]      stateQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regionQ <= OFFSCREEN;
      offXQ   <= '0;
      offYQ   <= '0;
      p1Q     <= 1'b0;
      p2Q     <= 1'b0;
      curQ    <= 1'b0;
      blinkQ  <= 1'b1;
      stateQ  <= '0;
    end else begin
      regionQ <= regionN;
      offXQ   <= offXn;
      offYQ   <= offYn;
      p1Q     <= srcP1[cellIdxN];
      p2Q     <= srcP2[cellIdxN];
      curQ    <= srcCurValid && (32'(srcCurIdx) < NC) && (srcCurIdx == cellIdxN);
      blinkQ  <= blinkOn;
      stateQ  <= srcState;
    end
  end

  // Stage 2: colour mux.
  logic       onFrame;
  logic [7:0] rgbN;

  always_comb begin
    onFrame = (32'(offXQ) < CURSOR_W) || (32'(offYQ) < CURSOR_W) ||
              (32'(offXQ) >= CELL_W - CURSOR_W) || (32'(offYQ) >= CELL_H - CURSOR_W);
    rgbN = '0;
    case (regionQ)
      OFFSCREEN: rgbN = '0;
      BORDER: begin
        case (stateQ)
          3'd4:    rgbN = blinkQ ? 8'hE0 : 8'h00;
          3'd5:    rgbN = 8'hFC;
          default: rgbN = 8'hE0;
        endcase
      end
      LINE: rgbN = '1;
      CELL: begin
        if (curQ && (stateQ == 3'd0 || stateQ == 3'd1) && onFrame)
          rgbN = 8'hFC;
        else if (p1Q && p2Q)
          rgbN = 8'hE3;
        else if (p1Q)
          rgbN = (stateQ == 3'd2 && !blinkQ) ? 8'h00 : 8'h03;
        else if (p2Q)
          rgbN = (stateQ == 3'd3 && !blinkQ) ? 8'h00 : 8'h1C;
        else
          rgbN = '0;
      end
      default: rgbN = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      {r, g, b} <= rgbN;
    end
  end

endmodule
